// File: rtl/retry_ctrl_if.sv
// Request/response bundle between the retry controller (master) and its
// requester/downstream environment (slave).
interface retry_ctrl_if #(
  parameter int MAX_RETRY = 3
);
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;

  logic          start;
  logic          abort;
  logic          req_valid;
  logic          req_ready;
  logic          rsp_valid;
  logic          rsp_ok;
  logic          busy;
  logic          done;
  logic          fail;
  logic [RW-1:0] retry_cnt;

  modport master (
    input  start, abort, req_ready, rsp_valid, rsp_ok,
    output req_valid, busy, done, fail, retry_cnt
  );

  modport slave (
    output start, abort, req_ready, rsp_valid, rsp_ok,
    input  req_valid, busy, done, fail, retry_cnt
  );
endinterface

// File: rtl/retry_ctrl.sv
// Retry controller: issues a request, waits under a saturating timeout,
// backs off and re-issues on timeout/error, gives up after MAX_RETRY retries.
module retry_ctrl #(
  parameter int TIMEOUT   = 100,
  parameter int MAX_RETRY = 3,
  parameter int BACKOFF   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  retry_ctrl_if.master bus
);
  localparam int TMAX = (TIMEOUT > BACKOFF) ? TIMEOUT : BACKOFF;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam int RW   = $clog2(MAX_RETRY + 1) + 1;

  localparam logic [TW-1:0] TIMEOUT_T   = TW'(TIMEOUT);
  localparam logic [TW-1:0] BACKOFF_T   = TW'(BACKOFF);
  localparam logic [RW-1:0] MAX_RETRY_T = RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_BACKOFF = 2'd3
  } state_t;

  state_t        state_reg;
  logic [TW-1:0] timer_reg;
  logic [RW-1:0] retry_cnt_reg;
  logic          done_reg;
  logic          fail_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      timer_reg     <= '0;
      retry_cnt_reg <= '0;
      done_reg      <= 1'b0;
      fail_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      fail_reg <= 1'b0;
      if (state_reg == ST_IDLE) begin
        // abort alongside start cancels the start
        if (bus.start && !bus.abort) begin
          state_reg     <= ST_ISSUE;
          timer_reg     <= '0;
          retry_cnt_reg <= '0;
        end
      end else if (bus.abort) begin
        state_reg <= ST_IDLE;
        timer_reg <= '0;
        fail_reg  <= 1'b1;
      end else begin
        case (state_reg)
          ST_ISSUE: begin
            if (bus.req_ready) begin
              state_reg <= ST_WAIT;
              timer_reg <= '0;
            end
          end
          ST_WAIT: begin
            // a response seen on the timeout cycle still wins
            if (bus.rsp_valid && bus.rsp_ok) begin
              state_reg <= ST_IDLE;
              timer_reg <= '0;
              done_reg  <= 1'b1;
            end else if (bus.rsp_valid || (timer_reg == TIMEOUT_T)) begin
              timer_reg <= '0;
              if (retry_cnt_reg == MAX_RETRY_T) begin
                state_reg <= ST_IDLE;
                fail_reg  <= 1'b1;
              end else begin
                state_reg     <= ST_BACKOFF;
                retry_cnt_reg <= retry_cnt_reg + 1'b1;
              end
            end else if (timer_reg != TIMEOUT_T) begin
              timer_reg <= timer_reg + 1'b1;
            end
          end
          ST_BACKOFF: begin
            if (timer_reg == BACKOFF_T) begin
              state_reg <= ST_ISSUE;
              timer_reg <= '0;
            end else begin
              timer_reg <= timer_reg + 1'b1;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            timer_reg <= '0;
          end
        endcase
      end
    end
  end

  assign bus.req_valid = (state_reg == ST_ISSUE);
  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.done      = done_reg;
  assign bus.fail      = fail_reg;
  assign bus.retry_cnt = retry_cnt_reg;
endmodule

// File: tb/tb_retry_ctrl.sv
// Bench for retry_ctrl: directed scenarios plus random traffic, checked every
// cycle against an absolute-deadline behavioural model.
module tb_retry_ctrl;
  localparam int TIMEOUT   = 4;
  localparam int MAX_RETRY = 2;
  localparam int BACKOFF   = 2;
  localparam int RW        = $clog2(MAX_RETRY + 1) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  retry_ctrl_if #(.MAX_RETRY(MAX_RETRY)) bus ();

  retry_ctrl #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .BACKOFF(BACKOFF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int n_cmp  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases are tracked with absolute cycle deadlines rather than a running timer.
  typedef enum int {P_IDLE, P_ISSUE, P_WAIT, P_BACKOFF} phase_t;
  phase_t  m_phase   = P_IDLE;
  int      m_retries = 0;
  bit      m_done    = 1'b0;
  bit      m_fail    = 1'b0;
  longint  cyc       = 0;
  longint  m_deadline = 0;
  longint  m_resume   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase   <= P_IDLE;
      m_retries <= 0;
      m_done    <= 1'b0;
      m_fail    <= 1'b0;
    end else begin
      cyc    <= cyc + 1;
      m_done <= 1'b0;
      m_fail <= 1'b0;
      if (m_phase == P_IDLE) begin
        if (bus.start && !bus.abort) begin
          m_phase   <= P_ISSUE;
          m_retries <= 0;
        end
      end else if (bus.abort) begin
        m_phase <= P_IDLE;
        m_fail  <= 1'b1;
      end else if (m_phase == P_ISSUE) begin
        if (bus.req_ready) begin
          m_phase    <= P_WAIT;
          m_deadline <= cyc + 1 + TIMEOUT;
        end
      end else if (m_phase == P_WAIT) begin
        if (bus.rsp_valid && bus.rsp_ok) begin
          m_phase <= P_IDLE;
          m_done  <= 1'b1;
        end else if (bus.rsp_valid || cyc == m_deadline) begin
          if (m_retries == MAX_RETRY) begin
            m_phase <= P_IDLE;
            m_fail  <= 1'b1;
          end else begin
            m_retries <= m_retries + 1;
            m_phase   <= P_BACKOFF;
            m_resume  <= cyc + 1 + BACKOFF;
          end
        end
      end else begin
        if (cyc == m_resume) m_phase <= P_ISSUE;
      end
    end
  end

  // ---------------- per-cycle compare + event monitor ----------------
  int  n_req_cyc = 0, n_req_rise = 0, n_busy = 0, n_done = 0, n_fail = 0;
  bit  prev_req = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_valid", int'(bus.req_valid), int'(m_phase == P_ISSUE));
      chk("busy",      int'(bus.busy),      int'(m_phase != P_IDLE));
      chk("done",      int'(bus.done),      int'(m_done));
      chk("fail",      int'(bus.fail),      int'(m_fail));
      chk("retry_cnt", int'(bus.retry_cnt), m_retries);
      if (bus.done && bus.fail) chk("done_and_fail", 1, 0);
      if (bus.req_valid) n_req_cyc++;
      if (bus.req_valid && !prev_req) n_req_rise++;
      if (bus.busy) n_busy++;
      if (bus.done) n_done++;
      if (bus.fail) n_fail++;
      prev_req = bus.req_valid;
    end else begin
      prev_req = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input bit a, input bit rr, input bit rv, input bit ok);
    bus.start = s; bus.abort = a; bus.req_ready = rr; bus.rsp_valid = rv; bus.rsp_ok = ok;
  endtask

  int s_rise, s_busy, s_done, s_req;
  bit seen;

  initial begin
    drive(0, 0, 0, 0, 0);
    #12;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_req_valid", int'(bus.req_valid), 0);
    chk("rst_retry_cnt", int'(bus.retry_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // 1: success on the 2nd WAIT cycle
    s_req = n_req_cyc;
    drive(1, 0, 1, 0, 0); tick();          // -> ISSUE
    drive(0, 0, 1, 0, 0); tick();          // -> WAIT (1st)
    tick();                                // WAIT (2nd)
    drive(0, 0, 1, 1, 1); tick();
    chk("s1_done", int'(bus.done), 1);
    chk("s1_busy", int'(bus.busy), 0);
    chk("s1_retry", int'(bus.retry_cnt), 0);
    drive(0, 0, 1, 0, 0); tick();
    chk("s1_done_pulse", int'(bus.done), 0);
    chk("s1_req_cycles", n_req_cyc - s_req, 1);

    // 2: never respond -> three attempts, then fail
    s_rise = n_req_rise; s_busy = n_busy; s_done = n_done;
    drive(1, 0, 1, 0, 0); tick();
    drive(0, 0, 1, 0, 0);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      seen = bus.fail;
    end
    chk("s2_fail_seen", int'(seen), 1);
    chk("s2_req_pulses", n_req_rise - s_rise, 3);
    chk("s2_busy_cycles", n_busy - s_busy, 24);
    chk("s2_retry", int'(bus.retry_cnt), 2);
    chk("s2_no_done", n_done - s_done, 0);
    tick();

    // 3: error response, stale response in BACKOFF, then success
    drive(1, 0, 1, 0, 0); tick();
    drive(0, 0, 1, 0, 0); tick();          // WAIT
    drive(0, 0, 1, 1, 0); tick();          // error -> BACKOFF
    drive(0, 0, 1, 1, 1); tick();          // stale in BACKOFF
    chk("s3_stale_done", int'(bus.done), 0);
    drive(0, 0, 1, 0, 0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      seen = bus.req_valid;
      if (!seen) tick();
    end
    chk("s3_reissue", int'(seen), 1);
    tick();                                // WAIT
    drive(0, 0, 1, 1, 1); tick();
    chk("s3_done", int'(bus.done), 1);
    chk("s3_retry", int'(bus.retry_cnt), 1);
    drive(0, 0, 1, 0, 0); tick();

    // 4: stale response in IDLE; response exactly on the timeout cycle
    drive(0, 0, 1, 1, 1); tick();
    chk("s4_idle_stale", int'(bus.busy), 0);
    drive(1, 0, 1, 0, 0); tick();
    drive(0, 0, 1, 0, 0); tick();          // WAIT timer 0
    repeat (TIMEOUT) tick();               // timer == TIMEOUT
    drive(0, 0, 1, 1, 1); tick();
    chk("s4_done", int'(bus.done), 1);
    chk("s4_retry", int'(bus.retry_cnt), 0);
    drive(0, 0, 1, 0, 0); tick();

    // 5: stalled ISSUE, abort in WAIT, reset in BACKOFF
    drive(1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0);
    repeat (20) tick();
    chk("s5_stall_req", int'(bus.req_valid), 1);
    chk("s5_stall_nofail", int'(bus.fail), 0);
    drive(0, 0, 1, 0, 0); tick();          // WAIT
    tick();
    drive(0, 1, 1, 0, 0); tick();
    chk("s5_abort_fail", int'(bus.fail), 1);
    chk("s5_abort_busy", int'(bus.busy), 0);
    drive(0, 0, 1, 0, 0); tick();
    chk("s5_fail_pulse", int'(bus.fail), 0);
    drive(1, 1, 1, 0, 0); tick();
    chk("s5_start_abort_idle", int'(bus.busy), 0);
    drive(1, 0, 1, 0, 0); tick();
    drive(0, 0, 1, 0, 0); tick();
    drive(0, 0, 1, 1, 0); tick();          // -> BACKOFF
    drive(0, 0, 1, 0, 0); tick();
    rst_n = 1'b0; #1;
    chk("s5_rst_busy", int'(bus.busy), 0);
    chk("s5_rst_retry", int'(bus.retry_cnt), 0);
    chk("s5_rst_done_fail", int'(bus.done | bus.fail | bus.req_valid), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // random traffic, checked each cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(3) == 0), ($urandom_range(39) == 0), $urandom_range(1) == 1,
            ($urandom_range(3) == 0), $urandom_range(1) == 1);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end
endmodule
